// File: rtl/simplerisc_pkg.sv
// Shared types for the SimpleRisc pipeline control blocks.
// Register width, link register and scoreboard/long-op types.
package simplerisc_pkg;

  localparam int REG_AW = 4;
  localparam logic [REG_AW-1:0] RA_REG = 4'd15;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
  } sb_entry_t;

  typedef enum logic [0:0] {
    LOP_IDLE = 1'b0,
    LOP_LONG = 1'b1
  } lop_state_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry in-flight destination tracker (EX, MA, RW).
// Flags a RAW hazard for the instruction sitting in OF.
module hazard_scoreboard
  import simplerisc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              freeze,
  input  logic              flush,
  input  logic              of_valid,
  input  logic [REG_AW-1:0] of_rs1,
  input  logic [REG_AW-1:0] of_rs2,
  input  logic              of_use_rs1,
  input  logic              of_use_rs2,
  input  logic [REG_AW-1:0] of_rd,
  input  logic              of_wr_rd,
  output logic              data_stall
);

  sb_entry_t sb_ex;
  sb_entry_t sb_ma;
  sb_entry_t sb_rw;
  sb_entry_t sb_new;
  logic      rs1_hit;
  logic      rs2_hit;

  function automatic logic hit(
    input sb_entry_t         e,
    input logic [REG_AW-1:0] r
  );
    return e.v && (e.rd == r);
  endfunction

  // RW is matched too: the regfile write lands on the same edge OF reads.
  always_comb begin
    rs1_hit = hit(sb_ex, of_rs1) | hit(sb_ma, of_rs1)
            | hit(sb_rw, of_rs1);
    rs2_hit = hit(sb_ex, of_rs2) | hit(sb_ma, of_rs2)
            | hit(sb_rw, of_rs2);
    data_stall = of_valid
               & ((of_use_rs1 & rs1_hit)
               |  (of_use_rs2 & rs2_hit));
    sb_new = '0;
    if (of_valid & of_wr_rd & !data_stall & !flush) begin
      sb_new.v  = 1'b1;
      sb_new.rd = of_rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_ex <= '0;
      sb_ma <= '0;
      sb_rw <= '0;
    end else if (!freeze) begin
      sb_rw <= sb_ma;
      sb_ma <= sb_ex;
      sb_ex <= sb_new;
    end
  end

endmodule

// File: rtl/pipeline_interlock.sv
// Issue control beside OF: RAW stalls, long-op freeze, branch flush.
// Priority is freeze, then flush, then data stall.
module pipeline_interlock
  import simplerisc_pkg::*;
#(
  parameter int LONG_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              of_valid,
  input  logic [REG_AW-1:0] of_rs1,
  input  logic [REG_AW-1:0] of_rs2,
  input  logic              of_use_rs1,
  input  logic              of_use_rs2,
  input  logic [REG_AW-1:0] of_rd,
  input  logic              of_wr_rd,
  input  logic              ex_long_start,
  input  logic              ex_branch_taken,
  output logic              pc_hold,
  output logic              of_hold,
  output logic              ex_bubble,
  output logic              flush,
  output logic              freeze,
  output logic [15:0]       stall_count
);

  localparam int CW = (LONG_LAT > 2) ? $clog2(LONG_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LONG_LAT - 2);

  lop_state_t    state;
  logic [CW-1:0] cnt;
  logic          data_stall;

  hazard_scoreboard u_sb (
    .clk        (clk),
    .reset      (reset),
    .freeze     (freeze),
    .flush      (flush),
    .of_valid   (of_valid),
    .of_rs1     (of_rs1),
    .of_rs2     (of_rs2),
    .of_use_rs1 (of_use_rs1),
    .of_use_rs2 (of_use_rs2),
    .of_rd      (of_rd),
    .of_wr_rd   (of_wr_rd),
    .data_stall (data_stall)
  );

  // Gated by reset so a long op or branch seen in reset waits for release.
  always_comb begin
    freeze = 1'b0;
    if (reset) begin
      unique case (1'b1)
        (state == LOP_IDLE): freeze = ex_long_start;
        (state == LOP_LONG): freeze = (cnt != '0);
        default:             freeze = 1'b0;
      endcase
    end
    flush     = reset & ex_branch_taken & !freeze;
    pc_hold   = freeze | (data_stall & !flush);
    of_hold   = pc_hold;
    ex_bubble = !freeze & (flush | data_stall);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LOP_IDLE;
      cnt   <= '0;
    end else begin
      unique case (1'b1)
        (state == LOP_IDLE): begin
          if (ex_long_start) begin
            state <= LOP_LONG;
            cnt   <= CNT_INIT;
          end
        end
        (state == LOP_LONG): begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else           state <= LOP_IDLE;
        end
        default: state <= LOP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (pc_hold && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_interlock.sv
// Bench for pipeline_interlock: directed scenarios plus random traffic
// compared every cycle against an in-bench behavioural model.
module tb_pipeline_interlock;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        of_valid;
  logic [3:0]  of_rs1, of_rs2, of_rd;
  logic        of_use_rs1, of_use_rs2, of_wr_rd;
  logic        ex_long_start, ex_branch_taken;
  logic        pc_hold, of_hold, ex_bubble, flush, freeze;
  logic [15:0] stall_count;

  pipeline_interlock #(.LONG_LAT(LAT)) dut (
    .clk             (clk),
    .reset           (reset),
    .of_valid        (of_valid),
    .of_rs1          (of_rs1),
    .of_rs2          (of_rs2),
    .of_use_rs1      (of_use_rs1),
    .of_use_rs2      (of_use_rs2),
    .of_rd           (of_rd),
    .of_wr_rd        (of_wr_rd),
    .ex_long_start   (ex_long_start),
    .ex_branch_taken (ex_branch_taken),
    .pc_hold         (pc_hold),
    .of_hold         (of_hold),
    .ex_bubble       (ex_bubble),
    .flush           (flush),
    .freeze          (freeze),
    .stall_count     (stall_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: in-flight writers, oldest last; freeze cycles still owed.
  bit         mv[3];
  logic [3:0] mrd[3];
  int         frz_left;
  bit         cool;
  int         mcnt;
  bit         e_frz, e_fl, e_ds, e_hold, e_bub;

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      mv[i]  = 0;
      mrd[i] = '0;
    end
    frz_left = 0;
    cool     = 0;
    mcnt     = 0;
  endtask

  task automatic model_eval();
    e_ds = 0;
    for (int i = 0; i < 3; i++) begin
      if (mv[i] && of_use_rs1 && mrd[i] == of_rs1) e_ds = 1;
      if (mv[i] && of_use_rs2 && mrd[i] == of_rs2) e_ds = 1;
    end
    e_ds   = e_ds && of_valid;
    e_frz  = reset && (frz_left > 0 || (!cool && ex_long_start));
    e_fl   = reset && ex_branch_taken && !e_frz;
    e_hold = e_frz || (e_ds && !e_fl);
    e_bub  = !e_frz && (e_fl || e_ds);
  endtask

  task automatic model_update();
    if (!e_frz) begin
      mv[2]  = mv[1];  mrd[2] = mrd[1];
      mv[1]  = mv[0];  mrd[1] = mrd[0];
      mv[0]  = of_valid && of_wr_rd && !e_ds && !e_fl;
      mrd[0] = mv[0] ? of_rd : 4'd0;
    end
    if (frz_left > 0) begin
      frz_left--;
      cool = (frz_left == 0);
    end else if (e_frz) begin
      frz_left = LAT - 2;
      cool     = (frz_left == 0);
    end else begin
      cool = 0;
    end
    if (e_hold && mcnt < 65535) mcnt++;
  endtask

  task automatic check(input string nm);
    tests++;
    if ({pc_hold, of_hold, ex_bubble, flush, freeze}
        !== {e_hold, e_hold, e_bub, e_fl, e_frz}
        || stall_count !== 16'(mcnt)) begin
      fails++;
      $display("FAIL %s t=%0t hold/ofh/bub/fl/frz=%b%b%b%b%b cnt=%0d expected %b%b%b%b%b cnt=%0d",
               nm, $time, pc_hold, of_hold, ex_bubble, flush, freeze,
               stall_count, e_hold, e_hold, e_bub, e_fl, e_frz, mcnt);
    end
  endtask

  task automatic lit(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic cycle(input string nm);
    #1;
    model_eval();
    check(nm);
    @(posedge clk);
    if (reset) model_update();
    #1;
  endtask

  task automatic set_of(input bit v, input bit u1, input logic [3:0] r1,
                        input bit u2, input logic [3:0] r2,
                        input bit w, input logic [3:0] rd);
    of_valid   = v;
    of_use_rs1 = u1; of_rs1 = r1;
    of_use_rs2 = u2; of_rs2 = r2;
    of_wr_rd   = w;  of_rd  = rd;
  endtask

  task automatic nops(input int n);
    set_of(0, 0, 0, 0, 0, 0, 0);
    ex_long_start   = 0;
    ex_branch_taken = 0;
    for (int i = 0; i < n; i++) cycle("idle");
  endtask

  int base;

  initial begin
    clear_model();
    reset = 1'b0;
    set_of(0, 0, 0, 0, 0, 0, 0);
    ex_long_start   = 1;
    ex_branch_taken = 1;
    @(posedge clk);
    #1;
    lit("reset_freeze", freeze, 0);
    lit("reset_flush", flush, 0);
    lit("reset_hold", pc_hold, 0);
    lit("reset_count", stall_count, 0);
    cycle("reset");
    ex_long_start   = 0;
    ex_branch_taken = 0;
    reset = 1'b1;
    nops(2);

    // RAW: add r1 then sub r2,r1,r3
    set_of(1, 0, 0, 0, 0, 1, 4'd1);
    cycle("raw_wr");
    set_of(1, 1, 4'd1, 1, 4'd3, 1, 4'd2);
    for (int i = 0; i < 3; i++) begin
      #1;
      lit("raw_hold", pc_hold, 1);
      lit("raw_bubble", ex_bubble, 1);
      cycle("raw_stall");
    end
    #1;
    lit("raw_issue", pc_hold, 0);
    lit("raw_count", stall_count, 3);
    cycle("raw_issue");
    nops(3);

    // Independent pair, then a late reader of r1
    set_of(1, 0, 0, 0, 0, 1, 4'd1);
    cycle("ind_wr");
    set_of(1, 1, 4'd2, 1, 4'd3, 1, 4'd4);
    #1;
    lit("ind_nostall", pc_hold, 0);
    cycle("ind_2");
    set_of(1, 1, 4'd1, 0, 0, 0, 0);
    #1;
    lit("ind_ma_hit", pc_hold, 1);
    for (int i = 0; i < 3; i++) cycle("ind_rd");
    nops(3);

    // Long op with a writer parked in EX across the freeze
    set_of(1, 0, 0, 0, 0, 1, 4'd5);
    cycle("long_wr");
    set_of(0, 0, 0, 0, 0, 0, 0);
    ex_long_start = 1;
    base = mcnt;
    for (int i = 0; i < 3; i++) begin
      #1;
      lit("long_freeze", freeze, 1);
      cycle("long");
    end
    set_of(1, 1, 4'd5, 0, 0, 0, 0);
    #1;
    lit("long_end", freeze, 0);
    lit("long_sb_held", ex_bubble, 1);
    lit("long_count", stall_count, 16'(base + 3));
    cycle("long_end");
    ex_long_start = 0;
    for (int i = 0; i < 3; i++) cycle("long_drain");
    nops(3);

    // Taken branch while OF has a hazard
    set_of(1, 0, 0, 0, 0, 1, 4'd6);
    cycle("br_wr");
    set_of(1, 1, 4'd6, 0, 0, 1, 4'd7);
    ex_branch_taken = 1;
    #1;
    lit("br_flush", flush, 1);
    lit("br_bubble", ex_bubble, 1);
    lit("br_hold", pc_hold, 0);
    cycle("br");
    ex_branch_taken = 0;
    set_of(1, 1, 4'd7, 0, 0, 0, 0);
    #1;
    lit("br_dropped", pc_hold, 0);
    cycle("br_after");
    nops(3);

    // Reset in the second freeze cycle
    ex_long_start = 1;
    cycle("rst_f1");
    #1;
    lit("rst_f2", freeze, 1);
    reset = 0;
    clear_model();
    #1;
    lit("rst_now", freeze, 0);
    cycle("rst_low");
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      lit("rst_refreeze", freeze, 1);
      cycle("rst_re");
    end
    #1;
    lit("rst_done", freeze, 0);
    cycle("rst_done");
    nops(3);

    // Long-op start concurrent with a branch
    ex_long_start   = 1;
    ex_branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      lit("lb_noflush", flush, 0);
      cycle("lb");
    end
    #1;
    lit("lb_flush", flush, 1);
    cycle("lb_end");
    nops(3);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      set_of($urandom_range(0, 3) != 0,
             $urandom_range(0, 1) == 1, 4'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1, 4'($urandom_range(0, 3)),
             $urandom_range(0, 2) != 0, 4'($urandom_range(0, 3)));
      if ($urandom_range(0, 19) == 0) ex_long_start = ~ex_long_start;
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 299) == 0) begin
        reset = 0;
        clear_model();
      end else begin
        reset = 1;
      end
      cycle("rand");
    end
    reset = 1;
    nops(3);

    // Saturation: long ops back to back with a self-dependent writer
    set_of(1, 1, 4'd1, 0, 0, 1, 4'd1);
    ex_long_start = 1;
    base = 0;
    for (int i = 0; i < 80000 && base < 200; i++) begin
      cycle("sat");
      if (mcnt == 65535) base++;
    end
    lit("sat_reached", 16'(base), 200);
    #1;
    lit("sat_count", stall_count, 16'hFFFF);
    nops(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_interlock.md
# pipeline_interlock

Hazard and sequencing controller for the five-stage SimpleRisc pipeline (IF, OF, EX, MA, RW). It sits beside the operand-fetch stage and decides, each cycle, whether the OF instruction may issue into EX. It tracks in-flight destination registers in a three-entry scoreboard, holds the pipeline for multi-cycle EX operations and flushes IF/OF on taken branches. It drives the hold, bubble and flush controls of the PC register, the IF/OF latch and the OF/EX latch.

## Interface
- `LONG_LAT`, default 4: total EX cycles of a long (multiply/divide) op; legal range ≥ 2.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `of_valid`  in  1  OF holds a real instruction (not a bubble).
- `of_rs1`, `of_rs2`  in  4 each  OF source register numbers.
- `of_use_rs1`, `of_use_rs2`  in  1 each  OF instruction reads the corresponding source.
- `of_rd`  in  4  OF destination register number (r15 for `call`).
- `of_wr_rd`  in  1  OF instruction writes `of_rd`.
- `ex_long_start`  in  1  EX holds a long op (level signal, held while the instruction stays in EX).
- `ex_branch_taken`  in  1  EX resolved a taken branch, `call` or `ret`.
- `pc_hold`  out  1  PC register keeps its value.
- `of_hold`  out  1  IF/OF latch keeps its value.
- `ex_bubble`  out  1  OF/EX latch loads a NOP (control bus all zero).
- `flush`  out  1  IF/OF latch loads a NOP; PC takes the branch target.
- `freeze`  out  1  every pipeline register (PC through MA/RW) holds.
- `stall_count`  out  16  saturating count of cycles with `pc_hold` high.

## Operation
- Scoreboard entries SB_EX, SB_MA and SB_RW each hold {v, rd}.
- Advance when `freeze` = 0: SB_RW ← SB_MA, SB_MA ← SB_EX, SB_EX ← {1, of_rd} only if `of_valid` & `of_wr_rd` & !`data_stall` & !`flush`; otherwise SB_EX ← {0, 0}.
- When `freeze` = 1: all entries hold.
- `data_stall` = `of_valid` & ((`of_use_rs1` & rs1 matches any valid entry) | (`of_use_rs2` & rs2 matches any valid entry)).
- SB_RW is included in the match because the register file writes at the RW edge while OF reads in the same cycle.
- There is no forwarding.
- Long-op FSM, states IDLE and LONG, with down-counter `cnt`:
  - IDLE & `ex_long_start`: go to LONG, `cnt` ← LONG_LAT−2, `freeze` = 1 this cycle.
  - LONG & `cnt` ≠ 0: `freeze` = 1, `cnt` decrements.
  - LONG & `cnt` = 0: `freeze` = 0, go to IDLE; `ex_long_start` is ignored in this cycle.
  - Result: `freeze` is high for LONG_LAT−1 cycles and the op occupies EX for LONG_LAT cycles.
- Priority is freeze > flush > data stall:
  - `flush` = `ex_branch_taken` & !`freeze`.
  - `pc_hold` = `of_hold` = `freeze` | (`data_stall` & !`flush`).
  - `ex_bubble` = !`freeze` & (`flush` | `data_stall`).
- `stall_count` increments by 1 on every cycle with `pc_hold` high and saturates at 0xFFFF.

## Timing
- Outputs are combinational from registered state plus the current inputs; there is no extra latency.
- Reset (async, `reset` = 0): scoreboard entries invalid, FSM IDLE, `cnt` = 0, `stall_count` = 0.
- Output values while `reset` is low:
  - `freeze` = `flush` = 0.
  - `ex_bubble` = `data_stall` and `pc_hold` = `of_hold` = `data_stall`, where `data_stall` evaluates to 0 against the cleared scoreboard.
  - A long op or branch seen during reset takes effect only after deassertion.
- Reset asserted mid-long-op returns the FSM to IDLE immediately.
- A dependent instruction following a writer stalls for exactly 3 cycles, until the writer leaves SB_RW.
- A taken branch with `data_stall` also high produces `flush`, and the OF instruction is dropped, not held.
- A long-op start concurrent with `ex_branch_taken` gives `freeze` = 1 and `flush` = 0; the branch is acted on when the freeze ends, provided it is still asserted.

## Structure
- Shared package `simplerisc_pkg`:
  - `REG_AW` = 4 and `RA_REG` = 4'd15.
  - Typedef `sb_entry_t` {v, rd}.
  - Long-op FSM state enum.
- Sub-module `hazard_scoreboard` contains the three entries, the shift logic and the match logic, and outputs `data_stall`.
- The FSM, the priority logic and `stall_count` remain in the top level.

## Test plan
- **RAW stall:** `add r1` issued, then `sub r2,r1,r3` → `pc_hold` = `of_hold` = `ex_bubble` = 1 for 3 cycles; the `sub` issues on cycle 4; `stall_count` = 3.
- **Independent pair:** `add r1`, then `add r4,r2,r3` → no stall; SB_EX, SB_MA and SB_RW show rd = 1 on successive cycles.
- **Long op with LONG_LAT = 4:** `ex_long_start` held → `freeze` = 1 for 3 cycles, then 0; the scoreboard is unchanged during the freeze; `stall_count` = 3.
- **Taken branch while OF has a hazard:** `ex_branch_taken` = 1 and `data_stall` = 1 → `flush` = 1, `ex_bubble` = 1, `pc_hold` = 0; SB_EX is invalid next cycle.
- **Reset mid-freeze:** `reset` pulled low in the 2nd freeze cycle → `freeze` = 0 immediately; after release, `ex_long_start` restarts a full 3-cycle freeze.
- **Saturation:** hold `data_stall` for 70000 cycles (forced scoreboard) → `stall_count` stays at 0xFFFF.
